addsub_seq_ctrl: RTL

Sequencing controller that performs NIBBLES×4-bit signed add/subtract by stepping one 4-bit add/sub slice across the operand words, least-significant nibble first. The controller holds the inter-nibble carry in a register and accepts operands through a valid/ready handshake. It returns the result, carry-out and signed overflow through a second valid/ready handshake. It sits between the operand source and consumers that need wider arithmetic than the 4-bit slice provides, without replicating adder hardware.

---
 rtl/addsub_seq_ctrl_if.sv | 21 ++
 rtl/addsub_seq_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/addsub_seq_ctrl_if.sv
// addsub_seq_ctrl_if: operand/result handshake bundle for addsub_seq_ctrl
//   master: operand source and result consumer (drives in_valid, op, a, b, flush, out_ready)
//   slave : controller (drives in_ready, out_valid, result, c_out, ovf)
//   ovf exists only when ADDSUB_SEQ_OVF_EN is defined
interface addsub_seq_ctrl_if #(parameter int NIBBLES = 4);
   localparam int W = 4 * NIBBLES;
   logic in_valid, in_ready, op, flush, out_valid, out_ready, c_out;
   logic [W-1:0] a, b, result;
`ifdef ADDSUB_SEQ_OVF_EN
   logic ovf;
   modport master (output in_valid, op, a, b, flush, out_ready,
                   input in_ready, out_valid, result, c_out, ovf);
   modport slave (input in_valid, op, a, b, flush, out_ready,
                  output in_ready, out_valid, result, c_out, ovf);
`else
   modport master (output in_valid, op, a, b, flush, out_ready,
                   input in_ready, out_valid, result, c_out);
   modport slave (input in_valid, op, a, b, flush, out_ready,
                  output in_ready, out_valid, result, c_out);
`endif
endinterface

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: signed W=4*NIBBLES add/sub stepped through one 4-bit slice, LS nibble first
//   clk : clock, rst : async active-high reset
//   bus : addsub_seq_ctrl_if.slave (operand handshake in, result handshake out, flush)
//   ADDSUB_SEQ_OVF_EN : when defined, adds the registered signed-overflow output ovf
module addsub_seq_ctrl #(parameter int NIBBLES = 4) (
   input logic clk,
   input logic rst,
   addsub_seq_ctrl_if.slave bus
);
   localparam int W = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q;
   logic [W-1:0] a_q, b_q, acc_q, result_q;
   logic [IW-1:0] idx_q;
   logic op_q, carry_q, c_out_q, in_ready_q, out_valid_q;
   logic [3:0] b_nib;
   logic [4:0] sum;
   // operands shift right each RUN cycle, so the active nibble is always [3:0]
   assign b_nib = op_q ? ~b_q[3:0] : b_q[3:0];
   assign sum = {1'b0, a_q[3:0]} + {1'b0, b_nib} + {4'd0, carry_q};
`ifdef ADDSUB_SEQ_OVF_EN
   logic ovf_q;
   logic [3:0] low3;
   // low3[3] is the carry into the top bit of the current nibble
   assign low3 = {1'b0, a_q[2:0]} + {1'b0, b_nib[2:0]} + {3'd0, carry_q};
   assign bus.ovf = ovf_q;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         acc_q <= '0;
         result_q <= '0;
         idx_q <= '0;
         op_q <= 1'b0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (bus.flush) begin
         state_q <= IDLE;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               a_q <= bus.a;
               b_q <= bus.b;
               op_q <= bus.op;
               carry_q <= bus.op;
               idx_q <= '0;
               in_ready_q <= 1'b0;
               state_q <= RUN;
            end
            RUN: begin
               a_q <= a_q >> 4;
               b_q <= b_q >> 4;
               // finished nibbles enter at the top and drift down to their final position
               acc_q <= {sum[3:0], acc_q[W-1:4]};
               carry_q <= sum[4];
               idx_q <= idx_q + 1'b1;
               if (idx_q == IW'(NIBBLES - 1)) begin
                  result_q <= {sum[3:0], acc_q[W-1:4]};
                  c_out_q <= sum[4];
`ifdef ADDSUB_SEQ_OVF_EN
                  ovf_q <= low3[3] ^ sum[4];
`endif
                  out_valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.in_ready = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result = result_q;
   assign bus.c_out = c_out_q;
endmodule
